// File: rtl/alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// alu_arbiter_ctrl : round-robin sharing of one combinational 16-bit ALU
//                    between two requesters, with per-opcode EXEC wait.
// Revision 1.0
// ============================================================================
module alu_arbiter_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req0_valid,
  input  logic [2:0]  i_req0_opcode,
  input  logic [15:0] i_req0_inp1,
  input  logic [15:0] i_req0_inp2,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [2:0]  i_req1_opcode,
  input  logic [15:0] i_req1_inp1,
  input  logic [15:0] i_req1_inp2,
  output logic        o_req1_ready,
  output logic [15:0] o_alu_inp1,
  output logic [15:0] o_alu_inp2,
  output logic [2:0]  o_alu_opcode,
  input  logic [31:0] i_alu_result,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_id,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic [15:0] o_ops_done
);

  localparam logic [2:0] C_OP_MUL  = 3'b010;
  localparam logic [2:0] C_OP_DIV  = 3'b011;
  localparam logic [3:0] C_MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] C_DIV_CNT = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ptr;
  logic [3:0]  r_cnt;
  logic        r_id;
  logic [15:0] r_alu_inp1;
  logic [15:0] r_alu_inp2;
  logic [2:0]  r_alu_opcode;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_id;
  logic        r_rsp_err;
  logic [15:0] r_ops_done;

  logic        w_grant;
  logic        w_gnt_id;
  logic [2:0]  w_gnt_op;
  logic [15:0] w_gnt_inp1;
  logic [15:0] w_gnt_inp2;
  logic [3:0]  w_lat_cnt;
  logic        w_exec_done;
  logic        w_rsp_fire;
  logic        w_div_zero;

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    w_grant    = (r_state == S_IDLE) && (i_req0_valid || i_req1_valid);
    w_gnt_id   = (i_req0_valid && i_req1_valid) ? r_ptr : i_req1_valid;
    w_gnt_op   = w_gnt_id ? i_req1_opcode : i_req0_opcode;
    w_gnt_inp1 = w_gnt_id ? i_req1_inp1   : i_req0_inp1;
    w_gnt_inp2 = w_gnt_id ? i_req1_inp2   : i_req0_inp2;
    case (w_gnt_op)
      C_OP_MUL: w_lat_cnt = C_MUL_CNT;
      C_OP_DIV: w_lat_cnt = C_DIV_CNT;
      default:  w_lat_cnt = 4'd0;
    endcase
    w_exec_done = (r_state == S_EXEC) && (r_cnt == 4'd0);
    w_rsp_fire  = (r_state == S_RESP) && i_rsp_ready;
    w_div_zero  = (r_alu_opcode == C_OP_DIV) && (r_alu_inp2 == 16'h0000);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)     w_state_nxt = S_EXEC;
      S_EXEC:  if (w_exec_done) w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_cnt        <= 4'd0;
      r_id         <= 1'b0;
      r_alu_inp1   <= 16'h0000;
      r_alu_inp2   <= 16'h0000;
      r_alu_opcode <= 3'b000;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 32'h0000_0000;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_ops_done   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_alu_opcode <= w_gnt_op;
        r_alu_inp1   <= w_gnt_inp1;
        r_alu_inp2   <= w_gnt_inp2;
        r_id         <= w_gnt_id;
        r_ptr        <= ~w_gnt_id;
        r_cnt        <= w_lat_cnt;
      end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // The ALU result is only trusted on the final EXEC cycle.
      if (w_exec_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_err   <= w_div_zero;
        r_rsp_data  <= w_div_zero ? 32'h0000_0000 : i_alu_result;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_ops_done  <= r_ops_done + 16'd1;
      end
    end
  end

  assign o_req0_ready = w_grant && !w_gnt_id && i_req0_valid;
  assign o_req1_ready = w_grant &&  w_gnt_id && i_req1_valid;
  assign o_alu_inp1   = r_alu_inp1;
  assign o_alu_inp2   = r_alu_inp2;
  assign o_alu_opcode = r_alu_opcode;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != S_IDLE);
  assign o_ops_done   = r_ops_done;

endmodule
`default_nettype wire

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
- Shares one 16-bit ALU instance between two requesters (req0, req1).
- Round-robin arbitration, valid/ready handshakes on request and response sides.
- Per-opcode multi-cycle wait so MUL/DIV can be constrained as multicycle paths.
- Flags divide-by-zero and keeps a completed-operation counter; sits between the issuing units and the combinational ALU.

Parameters:
- MUL_LAT, 2, cycles in EXEC before sampling the ALU result for opcode 010 (legal range 1..15).
- DIV_LAT, 4, cycles in EXEC for opcode 011 (legal range 1..15).
- All other opcodes use 1 EXEC cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_opcode  in  3  000 add, 001 sub, 010 mul, 011 div, 100 or, 101 and, 110 ~inp1, 111 ~inp2.
- req0_inp1  in  16  operand 1.
- req0_inp2  in  16  operand 2.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_opcode, req1_inp1, req1_inp2, req1_ready: same as req0 for requester 1.
- alu_inp1  out  16  registered operand to the ALU.
- alu_inp2  out  16  registered operand to the ALU.
- alu_opcode  out  3  registered opcode to the ALU.
- alu_result  in  32  ALU combinational result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  captured result.
- rsp_id  out  1  requester that issued the operation.
- rsp_err  out  1  divide by zero.
- busy  out  1  high whenever state != IDLE.
- ops_done  out  16  count of completed response handshakes, wraps 0xFFFF->0.

Behaviour:
- States: IDLE, EXEC, RESP. Reset (rst=1 at a clk edge) forces from any state, including mid-operation:
  - state=IDLE
  - all outputs 0: alu_inp1/inp2/opcode=0, rsp_*=0, ops_done=0
  - round-robin pointer=0 (req0 favoured)
  - EXEC counter=0
  - An in-flight operation is discarded with no response.
- reqN_ready is combinational: high only in IDLE, for the granted requester, and only when reqN_valid=1. At most one ready per cycle; ready never asserts outside IDLE.
- Arbitration in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by the pointer is granted.
  - After each grant the pointer moves to the non-granted requester.
  - Pointer unchanged when there is no grant.
- On grant at edge T:
  - Latch the granted opcode/inp1/inp2 into alu_* registers and its index into the id register.
  - Load the EXEC counter with lat-1, where lat = MUL_LAT for 010, DIV_LAT for 011, else 1.
  - Go to EXEC.
- EXEC:
  - alu_* held stable.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture on the next edge, go to RESP, and set:
    - rsp_data = alu_result
    - rsp_id = latched id
    - rsp_err = 0
  - Divide-by-zero exception (opcode 011 with alu_inp2==0): rsp_data=0, rsp_err=1, ALU output ignored.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id/rsp_err held stable until rsp_ready=1.
  - On a handshake edge: rsp_valid->0, ops_done+1, state->IDLE.
  - No new grant in that same cycle, so issue-to-issue minimum is lat+2 cycles.
- Latency:
  - Request accepted in cycle T; rsp_valid first high in cycle T+lat+1.
  - add (lat=1): accept T, EXEC T+1, rsp_valid T+2.
- Width rules:
  - rsp_data is the full 32-bit ALU result with no truncation.
  - sub underflow is passed through exactly as the ALU produces it.
- Requester inputs are not sampled outside the grant cycle; changes while not ready have no effect.
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- Reset, then req0 add 0x0003+0x0004 -> req0_ready in accept cycle; rsp_valid 2 cycles later; rsp_data=0x00000007, rsp_id=0, rsp_err=0, ops_done=1.
- Both valid every cycle, rsp_ready=1 tied high:
  - grants alternate req0, req1, req0, ... (first grant req0 after reset)
  - never two readys at once
  - rsp_id alternates.
- req1 mul 0xFFFF*0xFFFF with MUL_LAT=2 -> rsp_valid exactly 3 cycles after accept; rsp_data=0xFFFE0001; alu_* stable throughout EXEC.
- div 0x0064/0x0000 -> rsp_err=1, rsp_data=0; then div 0x0064/0x0007 with DIV_LAT=4 -> rsp_data=0x0000000E, rsp_valid 5 cycles after accept.
- Back-pressure: rsp_ready=0 for 6 cycles in RESP -> rsp_* held, busy=1, no reqN_ready; on rsp_ready=1 -> single ops_done increment, IDLE next cycle.
- rst asserted during EXEC of a div -> next cycle IDLE, rsp_valid=0, ops_done=0, pointer favours req0; a following req0 op completes normally.
